cube_frame_tx: RTL and testbench

Host-side frame transmitter for the CUBE0414 LED cube byte protocol. It reads a 512-pixel, 24-bit frame buffer (8 layers × 64 pixels) through a synchronous read port. It emits the framed byte stream that the cube-side layer controller consumes: a command byte with dc low, then data bytes with dc high. It sits between the frame-buffer RAM and the SPI byte shifter, and uses a valid/ready handshake on the byte side.

---
 rtl/cube_frame_tx_if.sv | 28 ++
 rtl/cube_frame_tx.sv | 218 +++++++++++++++++++++
 tb/tb_cube_frame_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cube_frame_tx_if.sv
// cube_frame_tx_if
//   Byte-side valid/ready link between the frame transmitter and the SPI byte
//   shifter.
//   byte_valid_out : byte_data_out/dc_out are valid (transmitter -> shifter)
//   byte_ready_in  : shifter accepts the byte      (shifter -> transmitter)
//   dc_out         : 0 = command byte, 1 = data byte
//   byte_data_out  : byte to transmit
//   master modport : transmitter side; slave modport : shifter side.
interface cube_frame_tx_if;
  logic       byte_valid_out;
  logic       byte_ready_in;
  logic       dc_out;
  logic [7:0] byte_data_out;

  modport master (
    output byte_valid_out,
    output dc_out,
    output byte_data_out,
    input  byte_ready_in
  );

  modport slave (
    input  byte_valid_out,
    input  dc_out,
    input  byte_data_out,
    output byte_ready_in
  );
endinterface

// File: rtl/cube_frame_tx.sv
// cube_frame_tx
//   Host-side frame transmitter for the CUBE0414 LED cube byte protocol.
//   Walks a 512-pixel, 24-bit frame buffer (8 layers x 64 pixels) through a
//   latency-1 synchronous read port and emits a command byte (dc=0) followed
//   by G,R,B data bytes (dc=1) per pixel over a valid/ready byte link.
//
//   Optional feature macro: CUBE_TX_ADDR_MAP_EN
//     When defined, the first sequence after reset is preceded by the
//     CMD_ADDR_WR command and 64 identity map bytes (0x00..0x3F).
//
//   Ports:
//     clk_in      : clock, rising edge
//     rst_n_in    : asynchronous active-low reset
//     start_in    : frame request, sampled only in IDLE
//     rd_addr_out : frame-buffer read address {layer[2:0], pixel[5:0]}
//     rd_data_in  : pixel word {G, R, B}, one cycle after rd_addr_out
//     byte_if     : byte link (valid/ready, dc, data), master side
//     busy_out    : sequence in progress
//     done_out    : one-cycle pulse after the final B byte of the frame
module cube_frame_tx #(
  parameter logic [7:0] CMD_ADDR_WR = 8'hcc,
  parameter logic [7:0] CMD_DATA_WR = 8'hda
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  output logic [8:0]             rd_addr_out,
  input  logic [23:0]            rd_data_in,
  cube_frame_tx_if.master        byte_if,
  output logic                   busy_out,
  output logic                   done_out
);

`ifdef CUBE_TX_ADDR_MAP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_MAP, S_FETCH, S_LOAD, S_BYTE, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_FETCH, S_LOAD, S_BYTE, S_DONE
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [8:0]  addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        dc_q, dc_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  sel_q, sel_d;
  logic [23:0] pix_q, pix_d;
`ifdef CUBE_TX_ADDR_MAP_EN
  logic        map_pending_q, map_pending_d;
  logic [5:0]  map_cnt_q, map_cnt_d;
`endif

  logic        xfer;
  logic [7:0]  first_cmd;

  assign xfer = valid_q & byte_if.byte_ready_in;

`ifdef CUBE_TX_ADDR_MAP_EN
  assign first_cmd = map_pending_q ? CMD_ADDR_WR : CMD_DATA_WR;
`else
  assign first_cmd = CMD_DATA_WR;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    dc_d    = dc_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sel_d   = sel_q;
    pix_d   = pix_q;
`ifdef CUBE_TX_ADDR_MAP_EN
    map_pending_d = map_pending_q;
    map_cnt_d     = map_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_CMD;
          valid_d = 1'b1;
          dc_d    = 1'b0;
          data_d  = first_cmd;
          busy_d  = 1'b1;
        end
      end
      S_CMD: begin
        if (xfer) begin
`ifdef CUBE_TX_ADDR_MAP_EN
          if (map_pending_q) begin
            // Address map follows immediately; keep valid asserted.
            state_d       = S_MAP;
            map_pending_d = 1'b0;
            map_cnt_d     = 6'd0;
            dc_d          = 1'b1;
            data_d        = 8'd0;
          end else begin
            state_d = S_FETCH;
            valid_d = 1'b0;
            addr_d  = 9'd0;
          end
`else
          state_d = S_FETCH;
          valid_d = 1'b0;
          addr_d  = 9'd0;
`endif
        end
      end
`ifdef CUBE_TX_ADDR_MAP_EN
      S_MAP: begin
        if (xfer) begin
          if (map_cnt_q == 6'd63) begin
            state_d = S_CMD;
            dc_d    = 1'b0;
            data_d  = CMD_DATA_WR;
          end else begin
            map_cnt_d = map_cnt_q + 6'd1;
            data_d    = {2'b00, map_cnt_q + 6'd1};
          end
        end
      end
`endif
      S_FETCH: begin
        // RAM samples rd_addr_out at the end of this cycle.
        state_d = S_LOAD;
      end
      S_LOAD: begin
        pix_d   = rd_data_in;
        state_d = S_BYTE;
        valid_d = 1'b1;
        dc_d    = 1'b1;
        data_d  = rd_data_in[23:16];
        sel_d   = 2'd0;
      end
      S_BYTE: begin
        if (xfer) begin
          unique case (sel_q)
            2'd0: begin
              data_d = pix_q[15:8];
              sel_d  = 2'd1;
            end
            2'd1: begin
              data_d = pix_q[7:0];
              sel_d  = 2'd2;
            end
            default: begin
              valid_d = 1'b0;
              // Terminal check comes before the increment so 511 never wraps.
              if (addr_q == 9'd511) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                addr_d  = addr_q + 9'd1;
                state_d = S_FETCH;
              end
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      addr_q  <= 9'd0;
      valid_q <= 1'b0;
      dc_q    <= 1'b0;
      data_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 2'd0;
`ifdef CUBE_TX_ADDR_MAP_EN
      map_pending_q <= 1'b1;
      map_cnt_q     <= 6'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      dc_q    <= dc_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
`ifdef CUBE_TX_ADDR_MAP_EN
      map_pending_q <= map_pending_d;
      map_cnt_q     <= map_cnt_d;
`endif
    end
  end

  // Pixel holding register is pure data; it is always reloaded before use.
  always_ff @(posedge clk_in) begin
    pix_q <= pix_d;
  end

  assign rd_addr_out            = addr_q;
  assign byte_if.byte_valid_out = valid_q;
  assign byte_if.dc_out         = dc_q;
  assign byte_if.byte_data_out  = data_q;
  assign busy_out               = busy_q;
  assign done_out               = done_q;

endmodule

// File: tb/tb_cube_frame_tx.sv
module tb_cube_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  rd_addr;
  logic [23:0] rd_data = 24'd0;
  logic        busy;
  logic        done;

  cube_frame_tx_if bif ();

  cube_frame_tx dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .start_in    (start),
    .rd_addr_out (rd_addr),
    .rd_data_in  (rd_data),
    .byte_if     (bif),
    .busy_out    (busy),
    .done_out    (done)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: latency-1 synchronous read.
  always @(posedge clk) rd_data <= {rd_addr[7:0], ~rd_addr[7:0], 8'h5a};

`ifdef CUBE_TX_ADDR_MAP_EN
  localparam bit MAP_EN = 1'b1;
`else
  localparam bit MAP_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [8:0] cap[$];
  logic [8:0] exp_q[$];
  int ncyc = 0;
  int done_cnt = 0;
  int done_ncyc = 0;
  int last_xfer_ncyc = 0;
  int rmode = 0;
  int stall = 0;
  int exp_len = 0;

  function automatic void build_exp(input bit with_map);
    logic [7:0] n8;
    exp_q.delete();
    if (with_map) begin
      exp_q.push_back({1'b0, 8'hcc});
      for (int k = 0; k < 64; k++) exp_q.push_back({1'b1, 8'(k)});
    end
    exp_q.push_back({1'b0, 8'hda});
    for (int n = 0; n < 512; n++) begin
      n8 = 8'(n);
      exp_q.push_back({1'b1, n8});
      exp_q.push_back({1'b1, ~n8});
      exp_q.push_back({1'b1, 8'h5a});
    end
    exp_len = exp_q.size();
  endfunction

  // Byte-link monitor: samples on the falling edge, ahead of the transfer edge.
  initial begin
    logic       pv, pr, pdc;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pdc = 1'b0; pd = 8'd0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst_n) begin
        if (pv && !pr) begin
          check("hold_valid", 32'(bif.byte_valid_out), 32'd1);
          check("hold_data", 32'({bif.dc_out, bif.byte_data_out}), 32'({pdc, pd}));
        end
        if (bif.byte_valid_out && bif.byte_ready_in) begin
          cap.push_back({bif.dc_out, bif.byte_data_out});
          last_xfer_ncyc = ncyc;
        end
        if (done) begin
          done_cnt++;
          done_ncyc = ncyc;
        end
        pv = bif.byte_valid_out; pr = bif.byte_ready_in;
        pdc = bif.dc_out; pd = bif.byte_data_out;
      end else begin
        pv = 1'b0;
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = stall 100 cycles on last B.
  initial begin
    bif.byte_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: bif.byte_ready_in = 1'($urandom_range(0, 1));
        2: begin
          if (cap.size() == exp_len - 1 && stall < 100) begin
            bif.byte_ready_in = 1'b0;
            stall++;
          end else begin
            bif.byte_ready_in = 1'b1;
          end
        end
        default: bif.byte_ready_in = 1'b1;
      endcase
    end
  end

  task automatic compare_stream(input string name);
    int bad;
    bad = -1;
    check({name, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
    end
    check({name, "_first_bad_idx"}, 32'(bad), 32'hffffffff);
  endtask

  // Runs one sequence up to done_out; lat < 0 skips the latency check.
  task automatic run_frame(input string name, input int mode, input bit with_map,
                           input int lat, input bit hold);
    int n0;
    int d0;
    bit seen;
    cap.delete();
    build_exp(with_map);
    stall = 0;
    rmode = mode;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    @(negedge clk); #1;
    n0 = ncyc;
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    check({name, "_cmd"}, 32'({bif.byte_valid_out, bif.dc_out, bif.byte_data_out}),
          32'({1'b1, 1'b0, with_map ? 8'hcc : 8'hda}));
    seen = 1'b0;
    for (int i = 0; i < 8000 && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      compare_stream(name);
      if (lat >= 0) check({name, "_latency"}, 32'(done_ncyc - n0), 32'(lat));
      check({name, "_done_after_last_xfer"}, 32'(done_ncyc - last_xfer_ncyc), 32'd1);
      check({name, "_busy_low_at_done"}, 32'({busy, bif.byte_valid_out}), 32'd0);
      @(negedge clk); #1;
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  typedef struct {
    int         idx;
    logic       dc;
    logic [7:0] val;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int off;
    bit ok;
    tbl[0] = '{0,    1'b0, 8'hda};
    tbl[1] = '{1,    1'b1, 8'h00};
    tbl[2] = '{2,    1'b1, 8'hff};
    tbl[3] = '{3,    1'b1, 8'h5a};
    tbl[4] = '{4,    1'b1, 8'h01};
    tbl[5] = '{5,    1'b1, 8'hfe};
    tbl[6] = '{766,  1'b1, 8'hff};
    tbl[7] = '{769,  1'b1, 8'h00};
    tbl[8] = '{1535, 1'b1, 8'h00};
    tbl[9] = '{1536, 1'b1, 8'h5a};

    // Reset state
    #23;
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_valid", 32'(bif.byte_valid_out), 32'd0);
    check("rst_dc", 32'(bif.dc_out), 32'd0);
    check("rst_data", 32'(bif.byte_data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // First frame, always ready
    run_frame("frame_ready", 0, MAP_EN, MAP_EN ? 2626 : 2561, 1'b0);
    off = MAP_EN ? 65 : 0;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].idx + off < cap.size())
        check($sformatf("vec%0d", i), 32'(cap[tbl[i].idx + off]), 32'({tbl[i].dc, tbl[i].val}));
      else
        check($sformatf("vec%0d_missing", i), 32'(cap.size()), 32'(tbl[i].idx + off + 1));
    end

    // Second start: data only, random ready
    run_frame("frame_random", 1, 1'b0, -1, 1'b0);

    // Ready held low for 100 cycles on the final B byte
    run_frame("frame_stall_last", 2, 1'b0, 2661, 1'b0);

    // start held high: one sequence, next begins after an IDLE cycle
    run_frame("frame_hold", 0, 1'b0, 2561, 1'b1);
    check("hold_idle_busy", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check("hold_restart", 32'({busy, bif.byte_valid_out, bif.dc_out, bif.byte_data_out}),
          32'({1'b1, 1'b1, 1'b0, 8'hda}));
    start = 1'b0;
    #2 rst_n = 1'b0;
    #5 rst_n = 1'b1;

    // Reset mid-frame at pixel 200
    cap.delete();
    rmode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (cap.size() >= off + 1 + 3 * 200 + 1) ok = 1'b1;
    end
    check("midrst_reached", 32'(ok), 32'd1);
    check("midrst_addr_before", 32'(rd_addr), 32'd200);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_addr", 32'(rd_addr), 32'd0);
    check("midrst_outs", 32'({bif.byte_valid_out, bif.dc_out, bif.byte_data_out, busy, done}), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    run_frame("frame_after_rst", 0, MAP_EN, MAP_EN ? 2626 : 2561, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
